pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 38 +++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the stall-request, exception and pipeline-control signals exchanged
// between the pipeline stages and the pipeline controller.
//   stallreq_from_id/ex/mem : per-stage stall requests (level-sensitive)
//   except_i                : one-cycle exception strobe from MEM
//   except_vector_i         : handler address, qualified by except_i
//   stall[5:0]              : per-stage hold (bit0 PC ... bit5 WB), 1 = hold
//   flush                   : clear all pipeline registers this cycle
//   new_pc                  : PC load value while flush = 1
//   stall_cycles            : saturating count of cycles with stall[0] = 1
//   stall_timeout           : sticky watchdog flag
// The master modport is the pipeline side; the slave modport is the controller.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic        stallreq_from_mem;
   logic        except_i;
   logic [31:0] except_vector_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        stall_timeout;

   modport master (
      output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      output except_i, except_vector_i,
      input  stall, flush, new_pc, stall_cycles, stall_timeout
   );

   modport slave (
      input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      input  except_i, except_vector_i,
      output stall, flush, new_pc, stall_cycles, stall_timeout
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central hazard/exception controller for a six-stage in-order pipeline.
// Resolves stall requests into per-stage hold bits, freezes the pipe for one
// cycle on an exception and then issues a single-cycle flush with the captured
// handler address. Also keeps a saturating stall-cycle counter and a sticky
// watchdog that trips after TIMEOUT_CYCLES consecutive stalled cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : pipeline_ctrl_if.slave (requests in, stall/flush/new_pc/stats out)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic              clk,
   input logic              rst,
   pipeline_ctrl_if.slave   bus
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] vector_q, vector_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic        stall_timeout_q, stall_timeout_d;
   logic [16:0] run_inc;

   logic [5:0]  stall_c;
   logic        flush_c;
   logic [31:0] new_pc_c;

   // State, captured vector and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RUN;
         vector_q        <= 32'h0000_0000;
         stall_cycles_q  <= 32'h0000_0000;
         run_cnt_q       <= 16'h0000;
         stall_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         vector_q        <= vector_d;
         stall_cycles_q  <= stall_cycles_d;
         run_cnt_q       <= run_cnt_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end

   // Next-state logic: an exception in RUN is accepted and its vector captured;
   // FLUSH always returns to RUN, so exceptions arriving there are dropped.
   always_comb begin
      state_d  = state_q;
      vector_d = vector_q;
      case (state_q)
         ST_RUN: begin
            if (bus.except_i) begin
               state_d  = ST_FLUSH;
               vector_d = bus.except_vector_i;
            end else begin
               state_d  = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Output logic: stall follows requests combinationally (exception freezes
   // everything, otherwise the oldest requesting stage wins). Reset masks all.
   always_comb begin
      stall_c  = 6'b000000;
      flush_c  = 1'b0;
      new_pc_c = 32'h0000_0000;
      if (rst) begin
         stall_c  = 6'b000000;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.except_i) begin
                  stall_c = 6'b111111;
               end else if (bus.stallreq_from_mem) begin
                  stall_c = 6'b011111;
               end else if (bus.stallreq_from_ex) begin
                  stall_c = 6'b001111;
               end else if (bus.stallreq_from_id) begin
                  stall_c = 6'b000111;
               end else begin
                  stall_c = 6'b000000;
               end
            end
            ST_FLUSH: begin
               flush_c  = 1'b1;
               new_pc_c = vector_q;
            end
            default: begin
               stall_c = 6'b000000;
            end
         endcase
      end
   end

   // Statistics: total stalled cycles and the watchdog run length. The run
   // counter is widened by one bit so its saturated value never re-matches.
   always_comb begin
      stall_cycles_d  = stall_cycles_q;
      run_cnt_d       = run_cnt_q;
      stall_timeout_d = stall_timeout_q;
      run_inc         = {1'b0, run_cnt_q} + 17'd1;
      if (stall_c[0]) begin
         if (stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
         end else begin
            stall_cycles_d = stall_cycles_q;
         end
         if (run_cnt_q != 16'hFFFF) begin
            run_cnt_d = run_inc[15:0];
         end else begin
            run_cnt_d = run_cnt_q;
         end
         if (run_inc == TIMEOUT_L) begin
            stall_timeout_d = 1'b1;
         end else begin
            stall_timeout_d = stall_timeout_q;
         end
      end else begin
         run_cnt_d = 16'h0000;
      end
   end

   assign bus.stall         = stall_c;
   assign bus.flush         = flush_c;
   assign bus.new_pc        = new_pc_c;
   assign bus.stall_cycles  = stall_cycles_q;
   assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized request/exception/reset traffic, all checked against a
// behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int TMO = 4;

   logic clk;
   logic rst;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // reference model state
   bit          m_in_flush;
   logic [31:0] m_vec;
   longint      m_count;
   int          m_run;
   bit          m_timeout;

   // last observed DUT outputs (for directed constant checks)
   logic [31:0] obs_stall;
   logic [31:0] obs_flush;
   logic [31:0] obs_pc;
   logic [31:0] obs_cyc;
   logic [31:0] obs_to;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_flush = 1'b0;
      m_vec      = 32'h0;
      m_count    = 0;
      m_run      = 0;
      m_timeout  = 1'b0;
   endtask

   // Number of held stages: a frozen pipe holds all six, otherwise the held
   // prefix reaches up to and including the requesting stage's input register.
   function automatic logic [31:0] model_stall(input logic r, id, ex, mem, exc);
      int n;
      n = 0;
      if (r || m_in_flush) n = 0;
      else if (exc) n = 6;
      else if (mem) n = 5;
      else if (ex)  n = 4;
      else if (id)  n = 3;
      return (32'd1 << n) - 32'd1;
   endfunction

   task automatic apply(input logic r, id, ex, mem, exc, input logic [31:0] vec);
      logic [31:0] es;
      logic [31:0] ef;
      logic [31:0] ep;
      int nr;
      @(negedge clk);
      rst                   = r;
      bus.stallreq_from_id  = id;
      bus.stallreq_from_ex  = ex;
      bus.stallreq_from_mem = mem;
      bus.except_i          = exc;
      bus.except_vector_i   = vec;
      #1;
      es = model_stall(r, id, ex, mem, exc);
      ef = (!r && m_in_flush) ? 32'd1 : 32'd0;
      ep = (!r && m_in_flush) ? m_vec : 32'h0;
      obs_stall = {26'd0, bus.stall};
      obs_flush = {31'd0, bus.flush};
      obs_pc    = bus.new_pc;
      obs_cyc   = bus.stall_cycles;
      obs_to    = {31'd0, bus.stall_timeout};
      check_val("stall", obs_stall, es);
      check_val("flush", obs_flush, ef);
      check_val("new_pc", obs_pc, ep);
      check_val("stall_cycles", obs_cyc, m_count[31:0]);
      check_val("stall_timeout", obs_to, {31'd0, m_timeout});
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (es[0]) begin
            if (m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
            nr = m_run + 1;
            if (nr == TMO) m_timeout = 1'b1;
            m_run = (nr > 65535) ? 65535 : nr;
         end else begin
            m_run = 0;
         end
         if (m_in_flush) begin
            m_in_flush = 1'b0;
         end else if (exc) begin
            m_in_flush = 1'b1;
            m_vec      = vec;
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst                   = 1'b1;
      bus.stallreq_from_id  = 1'b0;
      bus.stallreq_from_ex  = 1'b0;
      bus.stallreq_from_mem = 1'b0;
      bus.except_i          = 1'b0;
      bus.except_vector_i   = 32'h0;
      repeat (2) @(posedge clk);
      model_reset();

      // reset state with inputs active: everything masked
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
      check_val("rst_stall", obs_stall, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("rst_cycles", obs_cyc, 32'h0);

      // single-cycle decode stall
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("id_stall", obs_stall, 32'h07);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("id_release", obs_stall, 32'h00);
      check_val("id_cycles", obs_cyc, 32'd1);

      // priority and same-cycle release
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_val("all_req", obs_stall, 32'h1F);
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check_val("drop_mem", obs_stall, 32'h0F);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // exception over an execute stall, then one flush
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
      check_val("exc_freeze", obs_stall, 32'h3F);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_val("exc_flush", obs_flush, 32'd1);
      check_val("exc_pc", obs_pc, 32'h40);
      check_val("exc_flush_stall", obs_stall, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("exc_flush_end", obs_flush, 32'd0);

      // exception during FLUSH is ignored
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
      check_val("b2b_pc", obs_pc, 32'h100);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("b2b_noflush", obs_flush, 32'd0);

      // reset during FLUSH aborts it
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055);
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0077);
      check_val("rstf_flush", obs_flush, 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("rstf_flush2", obs_flush, 32'd0);
      check_val("rstf_cycles", obs_cyc, 32'd0);
      check_val("rstf_to", obs_to, 32'd0);

      // watchdog: 3 stalled, 1 free, 4 stalled
      repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("wd_first_run", obs_to, 32'd0);
      repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("wd_trip", obs_to, 32'd1);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("wd_sticky", obs_to, 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         apply(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 7) == 0),
               $urandom());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
